xor_share_ctrl: RTL and testbench
=================================

// Module: xor_share_ctrl
// PURPOSE
//  Schedules one shared 1-bit xorgate instance among N requesters, each submitting W-bit operand pairs.
//  Round-robin arbiter grants one requester and latches its operands.
//  The controller then streams them LSB-first through the external gate, one bit per clock,
//  and returns the W-bit XOR result tagged with the requester id.
//  Sits between the requesting lab datapaths and a single xorgate(a, b, y) cell.
// PARAMETERS
//  N    4   number of requesters (>=2)
//  W    8   operand/result width in bits (>=2)
//  IDW  $clog2(N)  localparam, width of res_id
// PORTS
//  clk      in   1      system clock, all state on rising edge
//  rst_n    in   1      asynchronous, active-low reset
//  req      in   N      per-requester request; hold high until own gnt bit seen
//  a_flat   in   N*W    operand A, requester i on bits [i*W +: W]
//  b_flat   in   N*W    operand B, same packing
//  gnt      out  N      one-hot grant pulse (one cycle) = operands captured
//  busy     out  1      high in SHIFT and DONE states
//  xg_a     out  1      bit driven to shared gate input a
//  xg_b     out  1      bit driven to shared gate input b
//  xg_y     in   1      shared gate output y (combinational from xg_a/xg_b)
//  res      out  W      last completed result; holds until next DONE
//  res_id   out  IDW    requester index of res
//  res_vld  out  1      one-cycle pulse: res/res_id valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE.
//   All outputs 0 (gnt, busy, xg_a, xg_b, res, res_id, res_vld).
//   Shift regs and counter 0; rr pointer last=N-1, so index 0 has first priority.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: on edge with |req=1:
//   - Pick first set req bit scanning last+1, last+2, ... mod N.
//   - Register gnt = onehot(winner); capture a_sh/b_sh from winner slice.
//   - Set cur_id=winner, last=winner, cnt=0, state=SHIFT.
//   With no req, stay in IDLE; gnt=0.
//  SHIFT (exactly W cycles, cnt 0..W-1):
//   - gnt high in the first SHIFT cycle only.
//   - xg_a=a_sh[0], xg_b=b_sh[0] (registered-shift LSB); each edge samples xg_y into r_sh MSB.
//   - Each edge shifts r_sh, a_sh and b_sh right one bit; cnt++.
//   - Edge with cnt==W-1: last bit captured, state=DONE.
//  DONE (1 cycle): res=r_sh, res_id=cur_id, res_vld=1. Next edge -> IDLE.
//  Outside SHIFT: xg_a=xg_b=0.
//  Latency: req sampled at edge 0 -> gnt during cycle 1 -> res_vld during cycle W+2.
//   Throughput one op per W+2 cycles.
//  req is ignored outside IDLE; req changes during SHIFT do not disturb the current op.
//  req dropped before grant is simply not considered; no error.
//  A requester holding req after gnt is re-eligible only per rr order; no back-to-back repeat if others wait.
//  res/res_id hold value between DONE pulses; no combinational path req -> gnt.
//  Reset mid-operation aborts: no res_vld, partial result discarded, rr pointer reset.
// TESTING
//  1. req=0001, A0=0xA5, B0=0x3C -> gnt=0001 cycle 1; xg_a bits 1,0,1,0,0,1,0,1 LSB-first;
//     res_vld cycle 10, res=0x99, res_id=0.
//  2. req=1111 held, distinct operands -> grants 0,1,2,3 in order, each 10 cycles apart;
//     every res matches A^B of res_id.
//  3. req0 and req2 held continuously -> grant sequence 0,2,0,2; req1/req3 never granted.
//  4. Operands 0xFF^0xFF -> 0x00; 0xFF^0x00 -> 0xFF; 0x00^0x00 -> 0x00; busy low in IDLE only.
//  5. rst_n low during SHIFT cnt=4 -> all outputs 0 immediately, no res_vld.
//     After release req=1010 -> gnt=0010 (pointer reset).
//  6. req3 pulses 1 cycle while busy, then drops -> never granted; no spurious gnt or res_vld.

Source files
------------

// File: rtl/xor_share_ctrl.sv
// xor_share_ctrl
//   Time-shares one external 1-bit XOR cell among N requesters. A round-robin
//   arbiter picks a requester and latches its W-bit operand pair. The pair is
//   then streamed LSB-first through the cell, one bit per clock. The W-bit
//   result is returned tagged with the requester index.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req[N]         per-requester request, held until its own gnt bit is seen
//   a_flat, b_flat operands, requester i on bits [i*W +: W]
//   gnt[N]         one-cycle one-hot grant, operands captured
//   busy           operation in flight (SHIFT or DONE)
//   xg_a, xg_b     bits driven to the shared gate; zero outside SHIFT
//   xg_y           shared gate output, combinational from xg_a/xg_b
//   res, res_id    last completed result and its requester, held between pulses
//   res_vld        one-cycle pulse marking a new res/res_id
module xor_share_ctrl #(
  parameter  int N   = 4,
  parameter  int W   = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_flat,
  input  logic [N*W-1:0]   b_flat,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic             xg_a,
  output logic             xg_b,
  input  logic             xg_y,
  output logic [W-1:0]     res,
  output logic [IDW-1:0]   res_id,
  output logic             res_vld
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [N-1:0][W-1:0]  a_arr, b_arr;
  logic [W-1:0]         a_sh, b_sh, r_sh;
  logic [CW-1:0]        cnt;
  logic [IDW-1:0]       last, cur_id;
  logic                 win_vld;
  logic [IDW-1:0]       win_id;
  logic [N-1:0]         win_oh;
  int                   idx;

  assign a_arr = a_flat;
  assign b_arr = b_flat;

  // Round-robin pick: first set req scanning last+1, last+2, ... (mod N).
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    win_oh         = '0;
    win_oh[win_id] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(W-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; the gate sees only the live LSBs during SHIFT.
  always_comb begin
    busy = (state != IDLE);
    xg_a = (state == SHIFT) & a_sh[0];
    xg_b = (state == SHIFT) & b_sh[0];
  end

  // Datapath: capture, serial shift, result publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      r_sh    <= '0;
      cnt     <= '0;
      cur_id  <= '0;
      last    <= IDW'(N-1);
      res     <= '0;
      res_id  <= '0;
      res_vld <= 1'b0;
    end else begin
      gnt     <= '0;
      res_vld <= 1'b0;
      case (state)
        IDLE: if (win_vld) begin
          gnt    <= win_oh;
          a_sh   <= a_arr[win_id];
          b_sh   <= b_arr[win_id];
          cur_id <= win_id;
          last   <= win_id;
          cnt    <= '0;
        end
        SHIFT: begin
          // Result enters at the MSB so the first (LSB) bit ends up at bit 0.
          r_sh <= {xg_y, r_sh[W-1:1]};
          a_sh <= {1'b0, a_sh[W-1:1]};
          b_sh <= {1'b0, b_sh[W-1:1]};
          cnt  <= cnt + CW'(1);
        end
        DONE: begin
          res     <= r_sh;
          res_id  <= cur_id;
          res_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_share_ctrl.sv
module tb_xor_share_ctrl;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   a_flat = '0, b_flat = '0;
  logic [N-1:0]     gnt;
  logic             busy, xg_a, xg_b, xg_y, res_vld;
  logic [W-1:0]     res;
  logic [IDW-1:0]   res_id;

  xor_share_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .busy(busy), .xg_a(xg_a), .xg_b(xg_b), .xg_y(xg_y),
    .res(res), .res_id(res_id), .res_vld(res_vld)
  );

  // The shared gate itself.
  assign xg_y = xg_a ^ xg_b;

  always #5 clk = ~clk;

  int n_tot = 0, n_pass = 0, cyc = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  // k = clocks since the capture edge (0 = nothing in flight). An op occupies
  // capture+1 .. capture+W+1; the result pulse lands at capture+W+2, which is
  // also an idle cycle able to accept the next request.
  function automatic int rr_pick(logic [N-1:0] r, int lst);
    for (int i = 1; i <= N; i++)
      if (r[(lst + i) % N]) return (lst + i) % N;
    return 0;
  endfunction

  int         k, m_last, m_w, m_id;
  logic [W-1:0] m_a, m_b, m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0; m_last <= N-1; m_w <= 0; m_id <= 0;
      m_a <= '0; m_b <= '0; m_res <= '0;
    end else if (k == 0 || k == W+2) begin
      if (|req) begin
        k      <= 1;
        m_w    <= rr_pick(req, m_last);
        m_last <= rr_pick(req, m_last);
        m_a    <= a_flat[rr_pick(req, m_last)*W +: W];
        m_b    <= b_flat[rr_pick(req, m_last)*W +: W];
      end else k <= 0;
    end else begin
      k <= k + 1;
      if (k == W+1) begin
        m_res <= m_a ^ m_b;
        m_id  <= m_w;
      end
    end
  end

  always @(negedge clk) if (rst_n && cmp_en) begin
    chk("gnt",     32'(gnt),     (k == 1) ? (32'd1 << m_w) : 32'd0);
    chk("busy",    32'(busy),    32'(k >= 1 && k <= W+1));
    chk("xg_a",    32'(xg_a),    (k >= 1 && k <= W) ? 32'(m_a[k-1]) : 32'd0);
    chk("xg_b",    32'(xg_b),    (k >= 1 && k <= W) ? 32'(m_b[k-1]) : 32'd0);
    chk("res_vld", 32'(res_vld), 32'(k == W+2));
    chk("res",     32'(res),     32'(m_res));
    chk("res_id",  32'(res_id),  32'(m_id));
  end

  // ---------------- helpers ----------------
  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_flat[i*W +: W] = a;
    b_flat[i*W +: W] = b;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"},  32'(gnt),  0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_xga"},  32'(xg_a), 0);
    chk({nm, "_xgb"},  32'(xg_b), 0);
    chk({nm, "_res"},  32'(res),  0);
    chk({nm, "_id"},   32'(res_id), 0);
    chk({nm, "_vld"},  32'(res_vld), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a grant pulse; returns index and cycle.
  task automatic wait_gnt(input string nm, output int id, output int c);
    id = -1; c = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) id = i;
        c = cyc;
        return;
      end
    end
    chk({nm, "_gnt_timeout"}, 1, 0);
  endtask

  task automatic wait_vld(input string nm, output int id, output logic [W-1:0] r);
    id = -1; r = '0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (res_vld) begin id = int'(res_id); r = res; return; end
    end
    chk({nm, "_vld_timeout"}, 1, 0);
  endtask

  // ---------------- stimulus ----------------
  int id, c, prev, g3;
  logic [W-1:0] r, xbits;
  logic [W-1:0] exp4 [N];

  initial begin
    #12;
    chk_all_zero("rst");
    @(negedge clk); rst_n = 1'b1; cmp_en = 1'b1;

    // Test 1: single request, literal timing and values.
    @(negedge clk);
    set_op(0, 8'hA5, 8'h3C); req = 4'b0001;
    @(posedge clk);                     // capture edge
    @(negedge clk);                     // cycle 1
    chk("t1_gnt", 32'(gnt), 32'h1);
    req = '0;
    for (int j = 0; j < W; j++) begin
      xbits[j] = xg_a;
      @(negedge clk);
    end
    chk("t1_xga_bits", 32'(xbits), 32'hA5);
    chk("t1_vld_early", 32'(res_vld), 0);
    @(negedge clk);                     // cycle 10
    chk("t1_vld", 32'(res_vld), 1);
    chk("t1_res", 32'(res), 32'h99);
    chk("t1_id", 32'(res_id), 0);

    // Test 2: all requesting after reset -> 0,1,2,3 spaced W+2 apart.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(8'h11 * (i+1)), W'(8'h0F << i));
    req = '1;
    prev = 0;
    for (int g = 0; g < N; g++) begin
      wait_gnt("t2", id, c);
      chk("t2_id", 32'(id), 32'(g));
      if (g > 0) chk("t2_gap", 32'(c - prev), 32'(W+2));
      prev = c;
    end
    req = '0;
    repeat (12) @(negedge clk);

    // Test 3: req0 and req2 held -> 0,2,0,2.
    do_reset();
    req = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      wait_gnt("t3", id, c);
      chk("t3_id", 32'(id), (g % 2 == 0) ? 32'd0 : 32'd2);
    end
    req = '0;
    repeat (12) @(negedge clk);

    // Test 6: req3 pulses one cycle while busy -> never granted.
    req = 4'b0001;
    wait_gnt("t6", id, c);
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    req = '0;
    g3 = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (gnt[3]) g3++;
    end
    chk("t6_no_gnt3", 32'(g3), 0);

    // Test 5: reset at cnt=4 aborts, pointer restarts at 0.
    set_op(0, 8'h5A, 8'hC3); req = 4'b0001;
    wait_gnt("t5", id, c);              // cycle 1, cnt=0
    req = '0;
    repeat (4) @(negedge clk);          // cycle 5, cnt=4
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t5");
    repeat (2) @(negedge clk);
    rst_n = 1'b1; req = 4'b1010;
    wait_gnt("t5b", id, c);
    chk("t5_gnt", 32'(gnt), 32'h2);
    req = '0;
    repeat (12) @(negedge clk);

    // Test 4: operand corners.
    set_op(1, 8'hFF, 8'hFF); set_op(2, 8'hFF, 8'h00); set_op(3, 8'h00, 8'h00);
    exp4[0] = 8'h00; exp4[1] = 8'h00; exp4[2] = 8'hFF; exp4[3] = 8'h00;
    req = 4'b1110;
    for (int g = 0; g < 3; g++) begin
      wait_vld("t4", id, r);
      if (id >= 0) chk("t4_res", 32'(r), 32'(exp4[id]));
    end
    req = '0;
    repeat (15) @(negedge clk);

    // Random traffic against the model.
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = '0;
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       set_op(i, 8'hFF, 8'hFF);
          1:       set_op(i, 8'h00, 8'hFF);
          default: set_op(i, W'($urandom), W'($urandom));
        endcase
      end
    end
    req = '0;
    repeat (15) @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
